// File: rtl/ip_sdram_arbiter_if.sv
// Requester, SDRAM command and read-return signals of the SDRAM arbiter.
// slave = arbiter side, master = requesters plus SDRAM controller side.
interface ip_sdram_arbiter_if;
   logic        vdp_req;
   logic        vdp_write;
   logic [22:0] vdp_address;
   logic [7:0]  vdp_wdata;
   logic        vdp_ack;
   logic [15:0] vdp_rdata;
   logic        vdp_rdata_en;
   logic        cpu_req;
   logic        cpu_write;
   logic [22:0] cpu_address;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic        cpu_rdata_en;
   logic        mem_req;
   logic        mem_write;
   logic [22:0] mem_address;
   logic [7:0]  mem_wdata;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic        mem_rdata_en;
   logic        err_orphan;

   modport slave (
      input  vdp_req, vdp_write, vdp_address, vdp_wdata,
      output vdp_ack, vdp_rdata, vdp_rdata_en,
      input  cpu_req, cpu_write, cpu_address, cpu_wdata,
      output cpu_ack, cpu_rdata, cpu_rdata_en,
      output mem_req, mem_write, mem_address, mem_wdata,
      input  mem_ready, mem_rdata, mem_rdata_en,
      output err_orphan
   );

   modport master (
      output vdp_req, vdp_write, vdp_address, vdp_wdata,
      input  vdp_ack, vdp_rdata, vdp_rdata_en,
      output cpu_req, cpu_write, cpu_address, cpu_wdata,
      input  cpu_ack, cpu_rdata, cpu_rdata_en,
      input  mem_req, mem_write, mem_address, mem_wdata,
      output mem_ready, mem_rdata, mem_rdata_en,
      input  err_orphan
   );
endinterface

// File: rtl/ip_sdram_arbiter.sv
// Two-requester SDRAM command arbiter: VDP priority, CPU starvation guard,
// in-order read return routing through a tag FIFO.
module ip_sdram_arbiter #(
   parameter int VDP_MAX_RUN = 4,
   parameter int TAG_DEPTH   = 4,
   parameter int TAG_BITS    = 2
) (
   input logic               clk,
   input logic               reset,
   input logic               sdram_busy,
   ip_sdram_arbiter_if.slave bus
);
   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [TAG_BITS:0] FULL    = (TAG_BITS + 1)'(TAG_DEPTH);
   localparam logic [3:0]        RUN_MAX = 4'(VDP_MAX_RUN);

   state_t              state;
   state_t              state_nxt;
   logic [TAG_BITS:0]   outstanding;
   logic [3:0]          run_cnt;
   logic [TAG_BITS-1:0] wr_ptr;
   logic [TAG_BITS-1:0] rd_ptr;
   logic                tag_mem [TAG_DEPTH];

   logic slot_free;
   logic pop;
   logic push;
   logic room;
   logic vdp_elig;
   logic cpu_elig;
   logic vdp_grant;
   logic cpu_grant;
   logic pop_tag;

   assign slot_free = !bus.mem_req || bus.mem_ready;
   assign pop       = bus.mem_rdata_en && (outstanding != '0);
   // A return in this cycle frees its slot for a read granted alongside it.
   assign room      = (outstanding < FULL) || pop;
   assign vdp_elig  = bus.vdp_req && (bus.vdp_write || room);
   assign cpu_elig  = bus.cpu_req && (bus.cpu_write || room);
   assign push      = (vdp_grant && !bus.vdp_write) ||
                      (cpu_grant && !bus.cpu_write);
   assign pop_tag   = tag_mem[rd_ptr];

   assign bus.vdp_ack = vdp_grant;
   assign bus.cpu_ack = cpu_grant;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      vdp_grant = 1'b0;
      cpu_grant = 1'b0;
      unique case (state)
         ST_INIT: begin
            if (!sdram_busy) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (sdram_busy) begin
               state_nxt = ST_INIT;
            end else if (slot_free) begin
               if (cpu_elig && (!vdp_elig || run_cnt == RUN_MAX))
                  cpu_grant = 1'b1;
               else if (vdp_elig)
                  vdp_grant = 1'b1;
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= cpu_grant;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.mem_req      <= 1'b0;
         bus.mem_write    <= 1'b0;
         bus.mem_address  <= '0;
         bus.mem_wdata    <= '0;
         bus.vdp_rdata    <= '0;
         bus.vdp_rdata_en <= 1'b0;
         bus.cpu_rdata    <= '0;
         bus.cpu_rdata_en <= 1'b0;
         bus.err_orphan   <= 1'b0;
         outstanding      <= '0;
         run_cnt          <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
      end else begin
         if (cpu_grant) begin
            bus.mem_req     <= 1'b1;
            bus.mem_write   <= bus.cpu_write;
            bus.mem_address <= bus.cpu_address;
            bus.mem_wdata   <= bus.cpu_wdata;
         end else if (vdp_grant) begin
            bus.mem_req     <= 1'b1;
            bus.mem_write   <= bus.vdp_write;
            bus.mem_address <= bus.vdp_address;
            bus.mem_wdata   <= bus.vdp_wdata;
         end else if (slot_free) begin
            bus.mem_req <= 1'b0;
         end

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         outstanding <= outstanding
                        + {{TAG_BITS{1'b0}}, push}
                        - {{TAG_BITS{1'b0}}, pop};

         bus.vdp_rdata_en <= pop && !pop_tag;
         bus.cpu_rdata_en <= pop && pop_tag;
         if (pop && !pop_tag) bus.vdp_rdata <= bus.mem_rdata;
         if (pop && pop_tag)  bus.cpu_rdata <= bus.mem_rdata;

         if (bus.mem_rdata_en && outstanding == '0)
            bus.err_orphan <= 1'b1;

         // Counts VDP wins only while the CPU is actually waiting.
         if (!bus.cpu_req || cpu_grant)
            run_cnt <= '0;
         else if (vdp_grant && run_cnt != RUN_MAX)
            run_cnt <= run_cnt + 4'd1;
      end
   end
endmodule

// File: tb/tb_ip_sdram_arbiter.sv
// Scoreboard bench for ip_sdram_arbiter: expected grants and read returns
// are queued by the stimulus and consumed by a negedge monitor.
module tb_ip_sdram_arbiter;
   typedef struct packed {
      logic        wr;
      logic [22:0] addr;
      logic [7:0]  wd;
   } req_t;

   typedef struct packed {
      logic        who;
      logic [22:0] addr;
   } gexp_t;

   typedef struct packed {
      logic        who;
      logic [15:0] data;
   } rexp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sdram_busy = 1'b1;

   int total = 0;
   int bad = 0;

   req_t        vq[$];
   req_t        cq[$];
   gexp_t       exp_g[$];
   rexp_t       exp_r[$];
   logic [15:0] ret_go_q[$];
   logic [15:0] ret_data_q[$];

   logic        auto_ret = 1'b0;
   logic        v_taken = 1'b0;
   logic        c_taken = 1'b0;
   logic        chk_cmd = 1'b0;
   logic [22:0] cmd_addr = '0;
   logic        prev_en = 1'b0;
   logic [15:0] prev_data = '0;

   ip_sdram_arbiter_if bus ();

   ip_sdram_arbiter #(
      .VDP_MAX_RUN (4),
      .TAG_DEPTH   (4),
      .TAG_BITS    (2)
   ) dut (
      .clk        (clk),
      .reset      (rst),
      .sdram_busy (sdram_busy),
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_g(input int n);
      int k = 0;
      while (exp_g.size() != 0 && k < n) begin
         step(1);
         k++;
      end
      check("wait_grants", 64'(exp_g.size()), 0);
   endtask

   task automatic wait_drain(input int n);
      int k = 0;
      while ((exp_g.size() != 0 || exp_r.size() != 0 ||
              ret_go_q.size() != 0) && k < n) begin
         step(1);
         k++;
      end
      check("wait_drain", 64'(exp_g.size() + exp_r.size()), 0);
   endtask

   task automatic do_reset(input logic busy);
      check("left_grants", 64'(exp_g.size()), 0);
      check("left_returns", 64'(exp_r.size()), 0);
      rst = 1'b1;
      sdram_busy = busy;
      auto_ret = 1'b0;
      vq.delete();
      cq.delete();
      exp_g.delete();
      exp_r.delete();
      ret_go_q.delete();
      ret_data_q.delete();
      step(2);
      @(negedge clk);
      check("rst_ctl", {bus.mem_req, bus.mem_write, bus.vdp_ack,
                        bus.cpu_ack, bus.vdp_rdata_en, bus.cpu_rdata_en,
                        bus.err_orphan}, 0);
      check("rst_data", {bus.mem_address, bus.mem_wdata}, 0);
      check("rst_rdata", {bus.vdp_rdata, bus.cpu_rdata}, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   // Requester model: holds each request until its ack is seen.
   initial begin
      req_t r;
      bus.vdp_req = 1'b0;
      bus.vdp_write = 1'b0;
      bus.vdp_address = '0;
      bus.vdp_wdata = '0;
      bus.cpu_req = 1'b0;
      bus.cpu_write = 1'b0;
      bus.cpu_address = '0;
      bus.cpu_wdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            bus.vdp_req = 1'b0;
            bus.cpu_req = 1'b0;
         end else begin
            if (!bus.vdp_req || v_taken) begin
               if (vq.size() > 0) begin
                  r = vq.pop_front();
                  bus.vdp_req = 1'b1;
                  bus.vdp_write = r.wr;
                  bus.vdp_address = r.addr;
                  bus.vdp_wdata = r.wd;
               end else begin
                  bus.vdp_req = 1'b0;
               end
            end
            if (!bus.cpu_req || c_taken) begin
               if (cq.size() > 0) begin
                  r = cq.pop_front();
                  bus.cpu_req = 1'b1;
                  bus.cpu_write = r.wr;
                  bus.cpu_address = r.addr;
                  bus.cpu_wdata = r.wd;
               end else begin
                  bus.cpu_req = 1'b0;
               end
            end
         end
      end
   end

   // SDRAM return model: one strobe per cycle from ret_go_q.
   initial begin
      bus.mem_rdata_en = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && ret_go_q.size() > 0) begin
            bus.mem_rdata_en = 1'b1;
            bus.mem_rdata = ret_go_q.pop_front();
         end else begin
            bus.mem_rdata_en = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      gexp_t g;
      rexp_t e;
      v_taken = bus.vdp_ack;
      c_taken = bus.cpu_ack;
      if (rst) begin
         chk_cmd = 1'b0;
      end else begin
         if (chk_cmd) begin
            check("cmd", {bus.mem_req, bus.mem_address}, {1'b1, cmd_addr});
            chk_cmd = 1'b0;
         end
         if (bus.vdp_ack && bus.cpu_ack) begin
            check("dual_ack", 2'b11, 2'b01);
         end else if (bus.vdp_ack || bus.cpu_ack) begin
            if (exp_g.size() == 0) begin
               check("unexp_ack", {bus.vdp_ack, bus.cpu_ack}, 0);
            end else begin
               g = exp_g.pop_front();
               check("grant_who", bus.cpu_ack, g.who);
               chk_cmd = 1'b1;
               cmd_addr = g.addr;
            end
         end
         if (bus.vdp_rdata_en && bus.cpu_rdata_en) begin
            check("dual_rdata_en", 2'b11, 2'b01);
         end else if (bus.vdp_rdata_en || bus.cpu_rdata_en) begin
            if (exp_r.size() == 0) begin
               check("unexp_rdata", {bus.vdp_rdata_en, bus.cpu_rdata_en}, 0);
            end else begin
               e = exp_r.pop_front();
               check("rdata_who", bus.cpu_rdata_en, e.who);
               check("rdata", bus.cpu_rdata_en ? bus.cpu_rdata : bus.vdp_rdata,
                     e.data);
               check("rdata_lat", prev_en, 1'b1);
            end
         end
         if (auto_ret && bus.mem_req && bus.mem_ready && !bus.mem_write &&
             ret_data_q.size() > 0)
            ret_go_q.push_back(ret_data_q.pop_front());
      end
      prev_en = bus.mem_rdata_en;
      prev_data = bus.mem_rdata;
   end

   initial begin
      logic who;
      int   vi;
      int   ci;
      bus.mem_ready = 1'b1;

      // Init hold-off while the SDRAM is busy.
      do_reset(1'b1);
      auto_ret = 1'b1;
      vq.push_back('{1'b0, 23'h000123, 8'h00});
      exp_g.push_back('{1'b0, 23'h000123});
      ret_data_q.push_back(16'h0123);
      exp_r.push_back('{1'b0, 16'h0123});
      repeat (20) begin
         @(negedge clk);
         check("busy_quiet", {bus.vdp_ack, bus.mem_req}, 0);
      end
      @(posedge clk);
      #2;
      sdram_busy = 1'b0;
      @(negedge clk);
      check("busy_fall_no_ack", {bus.vdp_ack, bus.mem_req}, 0);
      @(negedge clk);
      check("first_ack", bus.vdp_ack, 1'b1);
      step(1);
      wait_drain(50);

      // Starvation guard: V,V,V,V,C,V,V,V,V,C,V,V.
      do_reset(1'b0);
      auto_ret = 1'b1;
      vi = 0;
      ci = 0;
      for (int k = 0; k < 12; k++) begin
         who = (k == 4 || k == 9);
         if (who) begin
            cq.push_back('{1'b0, 23'h000300 + 23'(ci), 8'h00});
            exp_g.push_back('{1'b1, 23'h000300 + 23'(ci)});
            ci++;
         end else begin
            vq.push_back('{1'b0, 23'h000200 + 23'(vi), 8'h00});
            exp_g.push_back('{1'b0, 23'h000200 + 23'(vi)});
            vi++;
         end
         ret_data_q.push_back(16'hA000 + 16'(k));
         exp_r.push_back('{who, 16'hA000 + 16'(k)});
      end
      wait_drain(100);

      // In-order routing of returns to their originators.
      do_reset(1'b0);
      vq.push_back('{1'b0, 23'h000010, 8'h00});
      exp_g.push_back('{1'b0, 23'h000010});
      wait_g(20);
      cq.push_back('{1'b0, 23'h000020, 8'h00});
      exp_g.push_back('{1'b1, 23'h000020});
      wait_g(20);
      vq.push_back('{1'b0, 23'h000011, 8'h00});
      exp_g.push_back('{1'b0, 23'h000011});
      wait_g(20);
      step(2);
      ret_go_q.push_back(16'h1111);
      ret_go_q.push_back(16'h2222);
      ret_go_q.push_back(16'h3333);
      exp_r.push_back('{1'b0, 16'h1111});
      exp_r.push_back('{1'b1, 16'h2222});
      exp_r.push_back('{1'b0, 16'h3333});
      wait_drain(50);

      // Full tag FIFO: CPU write passes, VDP read waits for a return.
      do_reset(1'b0);
      for (int k = 0; k < 4; k++) begin
         vq.push_back('{1'b0, 23'h000400 + 23'(k), 8'h00});
         exp_g.push_back('{1'b0, 23'h000400 + 23'(k)});
      end
      wait_g(30);
      step(2);
      vq.push_back('{1'b0, 23'h000404, 8'h00});
      cq.push_back('{1'b1, 23'h000500, 8'hC3});
      exp_g.push_back('{1'b1, 23'h000500});
      exp_g.push_back('{1'b0, 23'h000404});
      step(6);
      check("full_vdp_stalled", 64'(exp_g.size()), 1);
      check("full_idle", bus.mem_req, 1'b0);
      ret_go_q.push_back(16'h4444);
      exp_r.push_back('{1'b0, 16'h4444});
      begin
         int k = 0;
         @(negedge clk);
         while (!bus.mem_rdata_en && k < 10) begin
            @(negedge clk);
            k++;
         end
      end
      check("ret_strobe_seen", bus.mem_rdata_en, 1'b1);
      check("grant_on_return", bus.vdp_ack, 1'b1);
      step(2);
      for (int k = 0; k < 4; k++) begin
         ret_go_q.push_back(16'h4401 + 16'(k));
         exp_r.push_back('{1'b0, 16'h4401 + 16'(k)});
      end
      wait_drain(50);

      // Back-pressure: latched command holds while mem_ready is low.
      do_reset(1'b0);
      bus.mem_ready = 1'b0;
      cq.push_back('{1'b1, 23'h000600, 8'h5A});
      exp_g.push_back('{1'b1, 23'h000600});
      wait_g(20);
      vq.push_back('{1'b1, 23'h000601, 8'hA5});
      exp_g.push_back('{1'b0, 23'h000601});
      repeat (10) begin
         @(negedge clk);
         check("stall_hold", {bus.vdp_ack, bus.mem_req, bus.mem_write,
                              bus.mem_address, bus.mem_wdata},
               {1'b0, 1'b1, 1'b1, 23'h000600, 8'h5A});
      end
      check("stall_no_grant", 64'(exp_g.size()), 1);
      @(posedge clk);
      #2;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      check("grant_on_accept", bus.vdp_ack, 1'b1);
      step(1);
      @(negedge clk);
      check("next_cmd", {bus.mem_write, bus.mem_wdata}, {1'b1, 8'hA5});
      wait_drain(20);

      // Orphan return.
      do_reset(1'b0);
      step(2);
      ret_go_q.push_back(16'hDEAD);
      step(4);
      @(negedge clk);
      check("orphan_flag", bus.err_orphan, 1'b1);
      check("orphan_no_rdata", {bus.vdp_rdata_en, bus.cpu_rdata_en}, 0);
      do_reset(1'b0);
      check("orphan_cleared", bus.err_orphan, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d want=0", 1);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ip_sdram_arbiter.md
Name: ip_sdram_arbiter

Overview:
Shares the single SDRAM command port between two requesters: the VDP (VRAM traffic) and the Z80 memory bus, which maps into the SDRAM above the VRAM window. Sits between the requesters and ip_sdram. Provides fixed VDP priority with a starvation guard for the CPU. Routes in-order read data back to its originator through a tag FIFO.

Parameters:
VDP_MAX_RUN, 4, maximum consecutive VDP grants while cpu_req is pending before the CPU is forced in (1..15).
TAG_DEPTH, 4, maximum outstanding reads; must be a power of 2 (2..16).
TAG_BITS, 2, log2(TAG_DEPTH).

Ports:
clk  in  1  system clock (86.4MHz domain).
reset  in  1  synchronous, active-high reset.
sdram_busy  in  1  SDRAM initialisation in progress; no grants while high.
vdp_req  in  1  VDP request; held high until vdp_ack.
vdp_write  in  1  1 = write, 0 = read.
vdp_address  in  23  VDP word/byte address.
vdp_wdata  in  8  VDP write data.
vdp_ack  out  1  one-cycle pulse: VDP request latched.
vdp_rdata  out  16  VDP read data.
vdp_rdata_en  out  1  one-cycle pulse: vdp_rdata valid.
cpu_req, cpu_write, cpu_address[22:0], cpu_wdata[7:0]  in  CPU request group; same rules as VDP.
cpu_ack  out  1  one-cycle pulse: CPU request latched.
cpu_rdata  out  16  CPU read data.
cpu_rdata_en  out  1  one-cycle pulse: cpu_rdata valid.
mem_req  out  1  command valid to SDRAM.
mem_write  out  1  command type.
mem_address  out  23  command address.
mem_wdata  out  8  command write data.
mem_ready  in  1  SDRAM accepts a command this cycle when mem_req=1.
mem_rdata  in  16  read return data; returns in command order.
mem_rdata_en  in  1  read return strobe.
err_orphan  out  1  sticky: mem_rdata_en arrived while no read was outstanding.

Behaviour:
- Reset values: all outputs 0. Tag FIFO empty, outstanding count 0, run counter 0, state INIT.
- States:
  - INIT: sdram_busy=1 or just reset. Go to RUN when sdram_busy=0.
  - RUN: normal arbitration. sdram_busy=1 in RUN returns to INIT; a latched mem_req is still held until accepted, and no new grants are made.
- Slot free when mem_req=0, or mem_req&mem_ready (transfer this cycle). Back-to-back commands are allowed, one per cycle.
- Grant, evaluated in RUN on a free slot. Eligible = req high and (write, or outstanding<TAG_DEPTH). Winner:
  - CPU if CPU eligible and (VDP not eligible, or run counter==VDP_MAX_RUN);
  - otherwise VDP if eligible;
  - otherwise none.
- On grant: the winner's write/address/wdata are registered into mem_*, mem_req=1, and the winner's ack pulses the same cycle. The requester may change or drop req the cycle after ack. With no grant on a free slot, mem_req goes to 0.
- Read grant: push a tag (0=VDP, 1=CPU) and increment outstanding in the grant cycle.
- mem_rdata_en: pop the tag. Next cycle, pulse the matching *_rdata_en with *_rdata=mem_rdata (1-cycle registered latency). Decrement outstanding.
- Read grant and return in the same cycle: push and pop both occur; count unchanged.
- Pointers wrap modulo TAG_DEPTH.
- FIFO full: reads are blocked and writes are still granted. This may let a CPU write pass a blocked VDP read; accepted.
- Return with FIFO empty: no rdata_en pulse, err_orphan=1 until reset.
- Run counter:
  - increments on each VDP grant while cpu_req=1, saturating at VDP_MAX_RUN;
  - clears on a CPU grant or whenever cpu_req=0.
- Reset mid-operation discards all state, including outstanding reads. ip_sdram shares the same reset, so no stale returns occur.
- Widths: outstanding is TAG_BITS+1 bits; run counter is 4 bits.

Test Plan:
1. Reset, sdram_busy=1 for 20 cycles, vdp_req=1 -> no vdp_ack or mem_req until the cycle after sdram_busy falls; then vdp_ack pulse, mem_req=1, mem_address=vdp_address.
2. vdp_req and cpu_req both held, both reads, mem_ready=1, reads returned promptly, VDP_MAX_RUN=4 -> grant order V,V,V,V,C,V,V,V,V,C…; each ack is exactly 1 cycle.
3. Alternating VDP/CPU reads with mem_rdata_en returning 0x1111, 0x2222, 0x3333 -> vdp_rdata_en(0x1111), cpu_rdata_en(0x2222), vdp_rdata_en(0x3333), each 1 cycle after its strobe.
4. mem_rdata_en held 0 with TAG_DEPTH=4 reads outstanding and a 5th VDP read plus a CPU write pending -> CPU write granted and VDP read stalled; one return -> VDP read granted in that same cycle.
5. mem_ready=0 for 10 cycles with a CPU write latched -> mem_req and mem_* stable, no further acks; mem_ready=1 -> transfer, next grant in the same cycle.
6. mem_rdata_en pulse with nothing outstanding -> no rdata_en, err_orphan=1; reset -> err_orphan=0.
